pwm_dac_driver: RTL and testbench

- Downstream stage of the waveform generator: consumes the 8-bit amplitude-scaled wave sample and drives a single-bit PWM output, which an external RC filter turns into the analog waveform.
- One-entry sample buffer with valid/ready handshake and a free-running PWM period counter.
- Sample updates are applied only at PWM period boundaries, so the output has no glitches.

---
 rtl/pwm_dac_driver_pkg.sv | 14 +
 rtl/pwm_dac_driver_if.sv | 15 +
 rtl/pwm_prescaler.sv | 37 +++
 rtl/pwm_dac_driver.sv | 153 +++++++++++++++
 tb/tb_pwm_dac_driver.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pwm_dac_driver_pkg.sv
// Shared types and constants for the PWM DAC output stage.
package pwm_dac_driver_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Matches the waveform generator's output sample width.
   localparam int DEFAULT_DATA_W = 8;
   localparam int UNDERRUN_CNT_W = 8;

endpackage

// File: rtl/pwm_dac_driver_if.sv
// Sample valid/ready handshake between the waveform generator and the PWM DAC driver.
interface pwm_dac_driver_if
   import pwm_dac_driver_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
);

   logic [DATA_W-1:0] SAMPLE;
   logic              SAMPLE_VALID;
   logic              SAMPLE_READY;

   modport master (output SAMPLE, output SAMPLE_VALID, input  SAMPLE_READY);
   modport slave  (input  SAMPLE, input  SAMPLE_VALID, output SAMPLE_READY);

endinterface

// File: rtl/pwm_prescaler.sv
// PWM tick generator: counts CLK cycles and emits a one-cycle tick every PRESCALE cycles.
module pwm_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0] cnt_q, cnt_d;
   logic            tc;

   assign tc   = (cnt_q == PS_W'(PRESCALE - 1));
   assign tick = en & tc & ~clr;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tc ? '0 : cnt_q + PS_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_dac_driver.sv
// PWM DAC driver: one-entry sample buffer, glitch-free duty update at period boundaries.
// Optional saturating underrun event counter enabled by PWM_DAC_UNDERRUN_CNT_EN.
//
// state | meaning
// IDLE  | output low, counters held at zero, waiting for ENB and a pending sample
// LOAD  | one cycle: pending sample becomes duty, period restarts from cnt=0
// RUN   | counting ticks, PWM_OUT = (cnt < duty), duty refresh at period end
module pwm_dac_driver
   import pwm_dac_driver_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int PRESCALE = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ENB,
   pwm_dac_driver_if.slave   smp_if,
   output logic              PWM_OUT,
   output logic              PERIOD_START,
`ifdef PWM_DAC_UNDERRUN_CNT_EN
   output logic [UNDERRUN_CNT_W-1:0] UNDERRUN_CNT,
`endif
   output logic              UNDERRUN
);

   localparam logic [DATA_W-1:0] CNT_MAX = '1;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] duty_q, duty_d;
   logic [DATA_W-1:0] pend_q, pend_d;
   logic              pend_full_q, pend_full_d;
   logic              pwm_q, pwm_d;
   logic              period_start_q, period_start_d;
   logic              underrun_q, underrun_d;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
   logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;
`endif
   logic              tick;
   logic              accept;

   pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (state_q == IDLE),
      .en   (state_q == RUN),
      .tick (tick)
   );

   assign accept = smp_if.SAMPLE_VALID & ~pend_full_q;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      duty_d         = duty_q;
      pend_d         = pend_q;
      pend_full_d    = pend_full_q;
      pwm_d          = pwm_q;
      period_start_d = 1'b0;
      underrun_d     = underrun_q;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
      ucnt_d         = ucnt_q;
`endif

      // Accept never collides with consumption: both need opposite pend_full values.
      if (accept) begin
         pend_d      = smp_if.SAMPLE;
         pend_full_d = 1'b1;
      end

      if (!ENB) begin
         state_d = IDLE;
         pwm_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               pwm_d = 1'b0;
               cnt_d = '0;
               if (pend_full_q) state_d = LOAD;
            end
            LOAD: begin
               duty_d         = pend_q;
               pend_full_d    = 1'b0;
               cnt_d          = '0;
               pwm_d          = 1'b0;
               period_start_d = 1'b1;
               state_d        = RUN;
            end
            RUN: begin
               pwm_d = (cnt_q < duty_q);
               if (tick) begin
                  cnt_d = cnt_q + DATA_W'(1);
                  if (cnt_q == CNT_MAX) begin
                     period_start_d = 1'b1;
                     if (pend_full_q) begin
                        duty_d      = pend_q;
                        pend_full_d = 1'b0;
                     end else begin
                        underrun_d = 1'b1;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
                        if (ucnt_q != '1) ucnt_d = ucnt_q + UNDERRUN_CNT_W'(1);
`endif
                     end
                  end
               end
            end
            default: begin
               state_d = IDLE;
               pwm_d   = 1'b0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         duty_q         <= '0;
         pend_q         <= '0;
         pend_full_q    <= 1'b0;
         pwm_q          <= 1'b0;
         period_start_q <= 1'b0;
         underrun_q     <= 1'b0;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
         ucnt_q         <= '0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         duty_q         <= duty_d;
         pend_q         <= pend_d;
         pend_full_q    <= pend_full_d;
         pwm_q          <= pwm_d;
         period_start_q <= period_start_d;
         underrun_q     <= underrun_d;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
         ucnt_q         <= ucnt_d;
`endif
      end
   end

   assign smp_if.SAMPLE_READY = ~pend_full_q;
   assign PWM_OUT             = pwm_q;
   assign PERIOD_START        = period_start_q;
   assign UNDERRUN            = underrun_q;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
   assign UNDERRUN_CNT        = ucnt_q;
`endif

endmodule

// File: tb/tb_pwm_dac_driver.sv
// Bench for pwm_dac_driver: two instances (PRESCALE=1 and 4) against a period-level model.
module tb_pwm_dac_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enb1 = 1'b0, enb4 = 1'b0;
   logic       sel = 1'b0;
   logic [7:0] smp = 8'h00;
   logic       vld = 1'b0;

   logic pwm1, ps1, und1, pwm4, ps4, und4;
   logic m_pwm, m_ps, m_und, m_rdy;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
   logic [7:0] ucnt1, ucnt4, m_ucnt_dut;
`endif

   always #5 clk = ~clk;

   pwm_dac_driver_if #(.DATA_W(8)) if1 ();
   pwm_dac_driver_if #(.DATA_W(8)) if4 ();

   assign if1.SAMPLE       = smp;
   assign if1.SAMPLE_VALID = vld & ~sel;
   assign if4.SAMPLE       = smp;
   assign if4.SAMPLE_VALID = vld & sel;

   pwm_dac_driver #(.DATA_W(8), .PRESCALE(1)) dut1 (
      .CLK(clk), .RST(rst), .ENB(enb1), .smp_if(if1),
      .PWM_OUT(pwm1), .PERIOD_START(ps1),
`ifdef PWM_DAC_UNDERRUN_CNT_EN
      .UNDERRUN_CNT(ucnt1),
`endif
      .UNDERRUN(und1)
   );

   pwm_dac_driver #(.DATA_W(8), .PRESCALE(4)) dut4 (
      .CLK(clk), .RST(rst), .ENB(enb4), .smp_if(if4),
      .PWM_OUT(pwm4), .PERIOD_START(ps4),
`ifdef PWM_DAC_UNDERRUN_CNT_EN
      .UNDERRUN_CNT(ucnt4),
`endif
      .UNDERRUN(und4)
   );

   assign m_pwm = sel ? pwm4 : pwm1;
   assign m_ps  = sel ? ps4  : ps1;
   assign m_und = sel ? und4 : und1;
   assign m_rdy = sel ? if4.SAMPLE_READY : if1.SAMPLE_READY;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
   assign m_ucnt_dut = sel ? ucnt4 : ucnt1;
`endif

   int checks   = 0;
   int failures = 0;

   // Model: accepted-but-unapplied samples, the duty of the running period, sticky flags.
   logic [7:0] tx[$];
   logic [7:0] mq[$];
   logic       acc_pend = 1'b0;
   logic [7:0] acc_val  = 8'h00;
   int         exp_duty = 0;
   int         m_ur     = 0;
   int         m_ucnt   = 0;
   int         in_period = 0;
   int         len = 0, highs = 0, ps_count = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int pre();
      return sel ? 4 : 1;
   endfunction

   task automatic step();
      @(negedge clk);
      if (in_period != 0) begin
         len++;
         if (m_pwm === 1'b1) highs++;
      end
      if (m_ps === 1'b1) begin
         if (in_period != 0) begin
            chk("period_len", len, 256 * pre());
            chk("high_cnt", highs, exp_duty * pre());
         end
         if (mq.size() > 0) begin
            exp_duty = int'(mq.pop_front());
         end else begin
            m_ur = 1;
            if (m_ucnt < 255) m_ucnt++;
         end
         ps_count++;
         chk("underrun", m_und, m_ur);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
         chk("underrun_cnt", m_ucnt_dut, m_ucnt);
`endif
         in_period = 1;
         len = 0;
         highs = 0;
      end
      if (acc_pend) begin
         mq.push_back(acc_val);
         acc_pend = 1'b0;
      end
      chk("ready", m_rdy, mq.size() == 0);
      vld = 1'b0;
      if (tx.size() > 0 && $urandom_range(3) != 0) begin
         smp = tx[0];
         vld = 1'b1;
         if (m_rdy === 1'b1) begin
            acc_pend = 1'b1;
            acc_val  = tx.pop_front();
         end
      end
   endtask

   task automatic run_until_ps(input int target, input int budget);
      int n = 0;
      while (ps_count < target && n < budget) begin
         step();
         n++;
      end
      chk("ps_count", ps_count, target);
   endtask

   task automatic wait_pwm_high(input int budget);
      int n = 0;
      while (m_pwm !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      chk("pwm_high_seen", m_pwm, 1);
   endtask

   initial begin
      // Reset values on both instances.
      repeat (3) @(negedge clk);
      chk("rst_pwm1", pwm1, 0);
      chk("rst_ps1", ps1, 0);
      chk("rst_und1", und1, 0);
      chk("rst_rdy1", if1.SAMPLE_READY, 1);
      chk("rst_pwm4", pwm4, 0);
      chk("rst_rdy4", if4.SAMPLE_READY, 1);
      rst = 1'b0;
      @(negedge clk);

      // PRESCALE=1: basic duty, extremes, backpressure, random duties, then underrun.
      sel  = 1'b0;
      enb1 = 1'b1;
      tx = '{8'h40, 8'h40, 8'h40, 8'h00, 8'hFF, 8'h10, 8'h20, 8'h30};
      for (int i = 0; i < 4; i++) tx.push_back(8'($urandom_range(255)));
      tx.push_back(8'h80);
      run_until_ps(15, 16 * 256 + 200);

      // Park a pending sample, then reset asynchronously while PWM_OUT is high.
      tx.push_back(8'h55);
      repeat (6) step();
      wait_pwm_high(300);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_pwm", pwm1, 0);
      chk("async_rst_rdy", if1.SAMPLE_READY, 1);
      chk("async_rst_und", und1, 0);
      chk("async_rst_ps", ps1, 0);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
      chk("async_rst_ucnt", ucnt1, 0);
`endif
      tx.delete();
      mq.delete();
      acc_pend  = 1'b0;
      vld       = 1'b0;
      in_period = 0;
      m_ur      = 0;
      m_ucnt    = 0;
      ps_count  = 0;
      exp_duty  = 0;
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      enb1 = 1'b0;

      // PRESCALE=4: 1024-cycle period, ENB drop mid-period, re-enable with pending sample.
      sel  = 1'b1;
      enb4 = 1'b1;
      tx = '{8'h02, 8'h02, 8'h05};
      run_until_ps(2, 2 * 1024 + 100);
      wait_pwm_high(1100);
      enb4 = 1'b0;
      in_period = 0;
      @(posedge clk);
      #1;
      chk("enb_drop_pwm", pwm4, 0);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_pwm", m_pwm, 0);
         chk("idle_ps", m_ps, 0);
      end
      chk("pend_retained", mq.size(), 1);
      enb4 = 1'b1;
      step();
      chk("load_ps_low", m_ps, 0);
      step();
      chk("fresh_ps", m_ps, 1);
      run_until_ps(ps_count + 1, 1100);
      repeat (4) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
